// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz hash block: datapath width, default
// seed-generator taps and the controller state encoding.
package toeplitz_pkg;

    localparam int          DATA_W       = 32;
    localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/toeplitz_lfsr.sv
// Diagonal-window generator: a Fibonacci-style LFSR that shifts the window left
// one bit per step, feeding back the parity of the tapped bits.
module toeplitz_lfsr
    import toeplitz_pkg::*;
#(
    parameter logic [DATA_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              step,
    output logic [DATA_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= {state[DATA_W-2:0], ^(state & POLY)};
        end
    end

endmodule

// File: rtl/toeplitz_hash.sv
// Bit-serial Toeplitz hash: reads NWORDS words from an upstream FIFO and folds
// each set input bit's diagonal window into a 32-bit accumulator.
module toeplitz_hash
    import toeplitz_pkg::*;
#(
    parameter int                NWORDS = 8,
    parameter logic [DATA_W-1:0] POLY   = DEFAULT_POLY
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] hash_out,
    output logic              hash_valid,
    input  logic              hash_ready,
    output logic              busy
);

    localparam logic [7:0] LAST_WORD = 8'(NWORDS - 1);

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] window;
    logic [4:0]        bit_cnt;
    logic [7:0]        word_cnt;
    logic              load_seed;
    logic              step_window;

    // The window is not reloaded between words, so consecutive words see
    // consecutive diagonals of one tall Toeplitz matrix.
    toeplitz_lfsr #(
        .POLY (POLY)
    ) u_lfsr (
        .clk      (clk_in),
        .rst_n    (rst),
        .load     (load_seed),
        .load_val (seed),
        .step     (step_window),
        .state    (window)
    );

    always_comb begin
        load_seed   = (state == IDLE) && start && (seed != '0);
        step_window = (state == SHIFT);
        fifo_rd_en  = (state == FETCH) && !fifo_empty;
        acc_next    = sh[0] ? (acc ^ window) : acc;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc        <= '0;
            sh         <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            hash_out   <= '0;
            hash_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_seed) begin
                        acc      <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (fifo_rd_en) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    sh      <= fifo_dout;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    acc     <= acc_next;
                    sh      <= sh >> 1;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        if (word_cnt == LAST_WORD) begin
                            hash_out   <= acc_next;
                            hash_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            word_cnt <= word_cnt + 8'd1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (hash_ready) begin
                        hash_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toeplitz_hash.sv
// Scoreboard bench for toeplitz_hash (NWORDS=2): a bit-serial reference model
// predicts each hash, and a behavioural FIFO feeds the block.
module tb_toeplitz_hash;
    import toeplitz_pkg::*;

    localparam int          NW      = 2;
    localparam logic [31:0] POLY_TB = 32'h80200003;
    localparam int          LAT     = 34 * NW;

    logic        clk_in;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] hash_out;
    logic        hash_valid;
    logic        hash_ready;
    logic        busy;

    int          tests_run    = 0;
    int          fail_count   = 0;
    int          accept_count = 0;
    int          rd_pulses    = 0;
    logic [31:0] sb[$];

    logic [31:0] fifo_mem[4096];
    int          wr_ptr      = 0;
    int          rd_ptr      = 0;
    logic        force_empty = 1'b0;

    toeplitz_hash #(
        .NWORDS (NW),
        .POLY   (POLY_TB)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .hash_out   (hash_out),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .busy       (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    // Upstream FIFO: data appears the cycle after the strobe; reset drops
    // anything still queued so an abandoned block leaves nothing behind.
    always @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= fifo_mem[rd_ptr % 4096];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk_in) begin
        if (rst && fifo_rd_en) rd_pulses++;
    end

    // Results are checked at the handshake that transfers them.
    always @(negedge clk_in) begin
        if (rst && hash_valid && hash_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                checkOutput("hash", hash_out, sb.pop_front());
            end
            accept_count++;
        end
    end

    function automatic logic [31:0] modelHash(input logic [31:0] s,
                                              input logic [31:0] w0,
                                              input logic [31:0] w1);
        logic [31:0] win;
        logic [31:0] acc;
        logic [31:0] wd;
        win = s;
        acc = '0;
        for (int k = 0; k < NW; k++) begin
            wd = (k == 0) ? w0 : w1;
            for (int b = 0; b < 32; b++) begin
                if (wd[b]) acc = acc ^ win;
                win = {win[30:0], ^(win & POLY_TB)};
            end
        end
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] w0,
                                 input logic [31:0] w1);
        fifo_mem[wr_ptr % 4096]       = w0;
        fifo_mem[(wr_ptr + 1) % 4096] = w1;
        wr_ptr = wr_ptr + 2;
        sb.push_back(modelHash(s, w0, w1));
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
    endtask

    task automatic waitValid(inout int n);
        while (!hash_valid && n < 400) begin
            tick();
            n++;
        end
        checkOutput("valid_timeout", {31'b0, hash_valid}, 32'd1);
    endtask

    task automatic waitAccept();
        int target;
        int n;
        target = accept_count + 1;
        n = 0;
        while (accept_count < target && n < 400) begin
            tick();
            n++;
        end
        checkOutput("accept_timeout", 32'(accept_count >= target), 32'd1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, {31'b0, hash_valid}, 32'd0);
        checkOutput({tag, "_busy"},  {31'b0, busy},       32'd0);
        checkOutput({tag, "_rden"},  {31'b0, fifo_rd_en}, 32'd0);
        checkOutput({tag, "_hash"},  hash_out,            32'd0);
    endtask

    initial begin
        int          n;
        int          p0;
        logic [31:0] s;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_d;

        rst        = 1'b0;
        start      = 1'b0;
        seed       = '0;
        hash_ready = 1'b1;
        repeat (3) tick();
        checkIdleOutputs("reset");
        rst = 1'b1;
        tick();

        // Unit seed and unit word: only the first diagonal contributes.
        applyStimulus(32'h00000001, 32'h00000001, 32'h00000000);
        n = 0;
        waitValid(n);
        checkOutput("latency_basic", 32'(n), 32'(LAT));
        checkOutput("hash_unit", hash_out, 32'h00000001);
        waitAccept();

        // All-zero data, plus a start while busy that must be ignored.
        p0 = rd_pulses;
        applyStimulus(32'h1234abcd, 32'h0, 32'h0);
        repeat (5) tick();
        start = 1'b1;
        seed  = 32'hdeadbeef;
        tick();
        start = 1'b0;
        waitAccept();
        checkOutput("rd_pulses", 32'(rd_pulses - p0), 32'(NW));

        // Ten empty cycles in FETCH add exactly ten cycles.
        force_empty = 1'b1;
        p0 = rd_pulses;
        applyStimulus(32'hcafef00d, 32'h5a5a5a5a, 32'h0f0f1234);
        repeat (10) tick();
        checkOutput("rd_while_empty", 32'(rd_pulses - p0), 32'd0);
        force_empty = 1'b0;
        n = 10;
        waitValid(n);
        checkOutput("latency_stall", 32'(n), 32'(LAT + 10));
        waitAccept();

        // Back-pressure in DONE, start on the accept cycle, and a zero seed.
        hash_ready = 1'b0;
        exp_d = modelHash(32'h87654321, 32'hffffffff, 32'h13579bdf);
        applyStimulus(32'h87654321, 32'hffffffff, 32'h13579bdf);
        n = 0;
        waitValid(n);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", {31'b0, hash_valid}, 32'd1);
            checkOutput("hold_hash", hash_out, exp_d);
            tick();
        end
        hash_ready = 1'b1;
        start      = 1'b1;
        seed       = 32'h11111111;
        tick();
        start = 1'b0;
        checkOutput("accept_busy", {31'b0, busy}, 32'd0);
        checkOutput("accept_valid", {31'b0, hash_valid}, 32'd0);
        tick();
        checkOutput("start_in_done_ignored", {31'b0, busy}, 32'd0);
        start = 1'b1;
        seed  = 32'h0;
        tick();
        start = 1'b0;
        tick();
        checkOutput("zero_seed_busy", {31'b0, busy}, 32'd0);

        // Reset mid-SHIFT with bit_cnt at 15 abandons the block.
        applyStimulus(32'h0badf00d, 32'h76543210, 32'hfedcba98);
        repeat (17) tick();
        checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        checkIdleOutputs("midreset");
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        applyStimulus(32'h2468ace0, 32'h31415926, 32'h27182818);
        waitAccept();

        // Random blocks against the reference model.
        for (int i = 0; i < 1000; i++) begin
            s = $urandom;
            if (s == 32'h0) s = 32'h1;
            w0 = $urandom;
            w1 = $urandom;
            applyStimulus(s, w0, w1);
            waitAccept();
        end

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
